// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - shared LED PWM constants, mode codes and sequencer state encoding
package led_pwm_pkg;

    localparam int N_LED  = 6;
    localparam int DUTY_W = 16;
    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_BREATHE = 2'b01,
        MODE_CHASE   = 2'b10,
        MODE_BLINK   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CALC    = 2'b01,
        ST_PRESENT = 2'b10
    } state_t;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// rtl/led_pattern_sequencer_if.sv - duty-word handoff from the sequencer to the PWM bank
interface led_pattern_sequencer_if #(
    parameter int N_LED  = led_pwm_pkg::N_LED,
    parameter int DUTY_W = led_pwm_pkg::DUTY_W
);
    logic [N_LED*DUTY_W-1:0] duty_flat;
    logic                    duty_valid;
    logic                    duty_ready;

    modport master (output duty_flat, output duty_valid, input duty_ready);
    modport slave  (input duty_flat, input duty_valid, output duty_ready);
endinterface

// File: rtl/led_step_tick.sv
// rtl/led_step_tick.sv - step prescaler: one-cycle tick every STEP_DIV enabled cycles
module led_step_tick #(
    parameter int STEP_DIV = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt;

    // tick is registered so it lines up with a mode_load pulse for the same latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (!en) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - pattern generator (OFF/BREATHE/CHASE/BLINK) feeding the PWM bank
module led_pattern_sequencer #(
    parameter int N_LED     = led_pwm_pkg::N_LED,
    parameter int DUTY_W    = led_pwm_pkg::DUTY_W,
    parameter int STEP_DIV  = 500000,
    parameter int STEP_SIZE = 200,
    parameter int PHASE_OFS = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode_sel,
    input  logic       mode_load,
    output logic [1:0] mode_cur,
    output logic       overrun,
    led_pattern_sequencer_if.master bus
);
    import led_pwm_pkg::*;

    localparam int IW = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam logic [IW-1:0]     LAST_IDX = IW'(N_LED - 1);
    localparam logic [DUTY_W-1:0] DMAX     = '1;
    localparam logic [31:0]       SS       = 32'(STEP_SIZE);

    state_t                  state;
    mode_t                   mode_q, mode_pend;
    logic                    init_path, load_pend, valid_q, blink_ph, tick;
    logic [N_LED*DUTY_W-1:0] duty_q, br_next, br_init;
    logic [N_LED-1:0]        dir, dir_next;
    logic [IW-1:0]           chase_idx, chase_nxt;

    led_step_tick #(.STEP_DIV(STEP_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    assign chase_nxt      = (chase_idx == LAST_IDX) ? '0 : chase_idx + 1'b1;
    assign bus.duty_flat  = duty_q;
    assign bus.duty_valid = valid_q;
    assign mode_cur       = mode_q;

    // dir bit: 0 = rising, 1 = falling; sums are done 32 bits wide so the clamp never wraps
    for (genvar g = 0; g < N_LED; g++) begin : g_ch
        logic [DUTY_W-1:0] cur, nxt;
        logic [31:0]       cur_ext;
        logic              nd;

        assign cur     = duty_q[g*DUTY_W +: DUTY_W];
        assign cur_ext = 32'(cur);
        assign br_init[g*DUTY_W +: DUTY_W] = DUTY_W'(g * PHASE_OFS);
        assign br_next[g*DUTY_W +: DUTY_W] = nxt;
        assign dir_next[g] = nd;

        always_comb begin
            nxt = cur;
            nd  = dir[g];
            if (!dir[g]) begin
                if (cur_ext + SS > 32'(DMAX)) begin
                    nxt = DMAX;
                    nd  = 1'b1;
                end else begin
                    nxt = cur + SS[DUTY_W-1:0];
                end
            end else begin
                if (cur_ext < SS) begin
                    nxt = '0;
                    nd  = 1'b0;
                end else begin
                    nxt = cur - SS[DUTY_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_OFF;
            mode_pend <= MODE_OFF;
            init_path <= 1'b0;
            load_pend <= 1'b0;
            valid_q   <= 1'b0;
            overrun   <= 1'b0;
            blink_ph  <= 1'b0;
            duty_q    <= '0;
            dir       <= '0;
            chase_idx <= '0;
        end else begin
            if (tick && state != ST_IDLE)
                overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    // a tick coinciding with a load is absorbed by the coming INIT update
                    if (load_pend) begin
                        state     <= ST_CALC;
                        init_path <= 1'b1;
                    end else if (tick && !mode_load) begin
                        state     <= ST_CALC;
                        init_path <= 1'b0;
                    end
                end
                ST_CALC: begin
                    state   <= ST_PRESENT;
                    valid_q <= 1'b1;
                    if (init_path) begin
                        mode_q <= mode_pend;
                        case (mode_pend)
                            MODE_OFF:     duty_q <= '0;
                            MODE_BREATHE: begin duty_q <= br_init; dir <= '0; end
                            MODE_CHASE: begin
                                chase_idx <= '0;
                                duty_q    <= {{((N_LED-1)*DUTY_W){1'b0}}, DMAX};
                            end
                            MODE_BLINK: begin blink_ph <= 1'b0; duty_q <= '0; end
                        endcase
                    end else begin
                        case (mode_q)
                            MODE_OFF:     duty_q <= '0;
                            MODE_BREATHE: begin duty_q <= br_next; dir <= dir_next; end
                            MODE_CHASE: begin
                                chase_idx <= chase_nxt;
                                for (int i = 0; i < N_LED; i++)
                                    duty_q[i*DUTY_W +: DUTY_W] <= (IW'(i) == chase_nxt) ? DMAX : '0;
                            end
                            MODE_BLINK: begin
                                blink_ph <= ~blink_ph;
                                duty_q   <= blink_ph ? '0 : {N_LED{DMAX}};
                            end
                        endcase
                    end
                end
                ST_PRESENT: begin
                    if (bus.duty_ready) begin
                        valid_q <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (mode_load) begin
                mode_pend <= mode_t'(mode_sel);
                load_pend <= 1'b1;
            end else if (state == ST_IDLE && load_pend) begin
                load_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - self-checking bench with a pattern-level reference model
module tb_led_pattern_sequencer;
    localparam int STEP = 200;
    localparam int PH   = 10000;
    localparam int DMAX = 65535;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, mode_load = 1'b0;
    logic [1:0] mode_sel = 2'd0;
    logic [1:0] mode_cur;
    logic       overrun;
    logic       cmp_on = 1'b0;

    led_pattern_sequencer_if #(.N_LED(6), .DUTY_W(16)) bus();

    led_pattern_sequencer #(
        .N_LED(6), .DUTY_W(16), .STEP_DIV(8), .STEP_SIZE(STEP), .PHASE_OFS(PH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode_sel  (mode_sel),
        .mode_load (mode_load),
        .mode_cur  (mode_cur),
        .overrun   (overrun),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, nprint = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (nprint < 40) $display("FAIL %s: got %0h want %0h", name, act, exp);
            nprint++;
        end
    endtask

    function automatic logic [95:0] vec6(input int a, b, c, d, e, f);
        logic [95:0] v;
        v = {f[15:0], e[15:0], d[15:0], c[15:0], b[15:0], a[15:0]};
        return v;
    endfunction

    function automatic logic [95:0] hot(input int k);
        logic [95:0] v;
        v = '0;
        v[k*16 +: 16] = 16'hffff;
        return v;
    endfunction

    // Reference model: timer as a count of enabled cycles, update pipeline as phases, patterns as int arrays
    int m_phase, m_cur, m_pend, m_cnt, m_chase;
    bit m_init, m_lp, m_valid, m_ovr, m_tick, m_blink;
    int m_duty [6];
    bit m_down [6];

    function automatic logic [95:0] m_vec();
        logic [95:0] v;
        for (int i = 0; i < 6; i++) v[i*16 +: 16] = m_duty[i][15:0];
        return v;
    endfunction

    task automatic m_update();
        if (m_init) begin
            m_cur = m_pend;
            for (int i = 0; i < 6; i++) m_duty[i] = 0;
            if (m_cur == 1) for (int i = 0; i < 6; i++) begin m_duty[i] = (i * PH) % 65536; m_down[i] = 0; end
            if (m_cur == 2) begin m_chase = 0; m_duty[0] = DMAX; end
            if (m_cur == 3) m_blink = 0;
        end else begin
            case (m_cur)
                1: for (int i = 0; i < 6; i++) begin
                    if (!m_down[i]) begin
                        if (m_duty[i] + STEP > DMAX) begin m_duty[i] = DMAX; m_down[i] = 1; end
                        else m_duty[i] += STEP;
                    end else begin
                        if (m_duty[i] < STEP) begin m_duty[i] = 0; m_down[i] = 0; end
                        else m_duty[i] -= STEP;
                    end
                end
                2: begin
                    m_chase = (m_chase + 1) % 6;
                    for (int i = 0; i < 6; i++) m_duty[i] = (i == m_chase) ? DMAX : 0;
                end
                3: begin
                    m_blink = !m_blink;
                    for (int i = 0; i < 6; i++) m_duty[i] = m_blink ? DMAX : 0;
                end
                default: for (int i = 0; i < 6; i++) m_duty[i] = 0;
            endcase
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_cur = 0; m_pend = 0; m_cnt = 0; m_chase = 0;
            m_init = 0; m_lp = 0; m_valid = 0; m_ovr = 0; m_tick = 0; m_blink = 0;
            for (int i = 0; i < 6; i++) begin m_duty[i] = 0; m_down[i] = 0; end
        end else begin
            if (m_tick && m_phase != 0) m_ovr = 1;
            case (m_phase)
                0: if (m_lp) begin m_phase = 1; m_init = 1; m_lp = 0; end
                   else if (m_tick && !mode_load) begin m_phase = 1; m_init = 0; end
                1: begin m_phase = 2; m_valid = 1; m_update(); end
                default: if (bus.duty_ready) begin m_valid = 0; m_phase = 0; end
            endcase
            if (mode_load) begin m_pend = mode_sel; m_lp = 1; end
            m_tick = 0;
            if (!en) m_cnt = 0;
            else if (m_cnt == 7) begin m_cnt = 0; m_tick = 1; end
            else m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (!rst && cmp_on) begin
            chk("cyc_valid", {95'd0, bus.duty_valid}, {95'd0, m_valid});
            chk("cyc_duty", bus.duty_flat, m_vec());
            chk("cyc_mode_cur", {94'd0, mode_cur}, 96'(m_cur));
            chk("cyc_overrun", {95'd0, overrun}, {95'd0, m_ovr});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [1:0] m);
        mode_sel  = m;
        mode_load = 1'b1;
        step();
        mode_load = 1'b0;
    endtask

    task automatic wait_hs(input string name, output logic [95:0] d);
        int k;
        k = 0;
        d = '0;
        while (k < 40) begin
            @(negedge clk);
            if (bus.duty_valid && bus.duty_ready) break;
            k++;
        end
        if (k >= 40) begin
            total++; bad++;
            $display("FAIL %s: handshake got 0 want 1 within 40 cycles", name);
        end else begin
            d = bus.duty_flat;
        end
        step();
    endtask

    logic [95:0] d, d0;
    int k, seen, hs;

    initial begin
        bus.duty_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cmp_on = 1'b1;
        chk("rst_valid", {95'd0, bus.duty_valid}, 96'd0);
        chk("rst_duty", bus.duty_flat, 96'd0);
        chk("rst_overrun", {95'd0, overrun}, 96'd0);
        chk("rst_mode_cur", {94'd0, mode_cur}, 96'd0);

        seen = 0;
        repeat (100) begin @(negedge clk); if (bus.duty_valid) seen++; end
        chk("idle_no_valid", 96'(seen), 96'd0);

        // BREATHE load: valid two edges after the load edge, then 407 steps through both clamps
        step();
        mode_sel = 2'd1; mode_load = 1'b1;
        @(posedge clk); #1 mode_load = 1'b0;
        k = 0;
        while (k < 10) begin @(posedge clk); k++; #1; if (bus.duty_valid) break; end
        chk("load_latency", 96'(k), 96'd2);
        chk("breathe_init", bus.duty_flat, vec6(0, 10000, 20000, 30000, 40000, 50000));
        step();
        en = 1'b1;
        for (int n = 1; n <= 407; n++) begin
            wait_hs("breathe_hs", d);
            if (n == 1)   chk("breathe_step1", d, vec6(200, 10200, 20200, 30200, 40200, 50200));
            if (n == 77)  chk("ch5_n77", 96'(d[80 +: 16]), 96'd65400);
            if (n == 78)  chk("ch5_clamp_top", 96'(d[80 +: 16]), 96'd65535);
            if (n == 79)  chk("ch5_down", 96'(d[80 +: 16]), 96'd65335);
            if (n == 405) chk("ch5_n405", 96'(d[80 +: 16]), 96'd135);
            if (n == 406) chk("ch5_clamp_zero", 96'(d[80 +: 16]), 96'd0);
            if (n == 407) chk("ch5_up_again", 96'(d[80 +: 16]), 96'd200);
        end

        // CHASE wrap
        en = 1'b0;
        repeat (6) step();
        pulse_load(2'd2);
        wait_hs("chase_init_hs", d);
        chk("chase_init", d, hot(0));
        chk("mode_cur_chase", {94'd0, mode_cur}, 96'd2);
        en = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            wait_hs("chase_hs", d);
            chk("chase_hot", d, hot(j % 6));
        end

        // backpressure across several ticks, BLINK loaded meanwhile
        bus.duty_ready = 1'b0;
        k = 0;
        while (k < 40) begin @(negedge clk); if (bus.duty_valid) break; k++; end
        d0 = bus.duty_flat;
        chk("held_is_hot2", d0, hot(2));
        step();
        pulse_load(2'd3);
        repeat (30) step();
        @(negedge clk);
        chk("held_valid", {95'd0, bus.duty_valid}, 96'd1);
        chk("held_duty", bus.duty_flat, d0);
        chk("overrun_set", {95'd0, overrun}, 96'd1);
        chk("mode_not_yet_blink", {94'd0, mode_cur}, 96'd2);
        step();
        bus.duty_ready = 1'b1;
        wait_hs("held_hs", d);
        chk("held_delivered", d, hot(2));
        wait_hs("blink_init_hs", d);
        chk("blink_init", d, 96'd0);
        chk("mode_cur_blink", {94'd0, mode_cur}, 96'd3);
        wait_hs("blink_step_hs", d);
        chk("blink_on", d, vec6(DMAX, DMAX, DMAX, DMAX, DMAX, DMAX));

        // load on the tick cycle: exactly one INIT update, no overrun
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        chk("overrun_cleared", {95'd0, overrun}, 96'd0);
        en = 1'b1;
        k = 0;
        while (k < 20) begin step(); if (m_tick) break; k++; end
        pulse_load(2'd1);
        hs = 0; d = '0;
        repeat (7) begin
            @(negedge clk);
            if (bus.duty_valid && bus.duty_ready) begin hs++; d = bus.duty_flat; end
        end
        chk("single_update", 96'(hs), 96'd1);
        chk("single_init", d, vec6(0, 10000, 20000, 30000, 40000, 50000));
        chk("no_overrun", {95'd0, overrun}, 96'd0);

        // reset during PRESENT drops valid immediately
        step();
        en = 1'b0; bus.duty_ready = 1'b0;
        repeat (6) step();
        pulse_load(2'd2);
        k = 0;
        while (k < 20) begin @(negedge clk); if (bus.duty_valid) break; k++; end
        chk("present_before_rst", {95'd0, bus.duty_valid}, 96'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", {95'd0, bus.duty_valid}, 96'd0);
        chk("rst_async_duty", bus.duty_flat, 96'd0);
        step();
        step();
        rst = 1'b0;

        // randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            en             = ($urandom_range(0, 9) != 0);
            mode_load      = ($urandom_range(0, 29) == 0);
            mode_sel       = 2'($urandom_range(0, 3));
            bus.duty_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        mode_load = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
